// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue path: ALU control codes,
// opcode/funct encodings and the operand-extension kinds.
package alu_pkg;

    localparam int CTRL_W = 4;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // How in2 is formed: register rt, sign-/zero-extended imm, or imm<<16
    typedef enum logic [1:0] {
        EXT_REG,
        EXT_SIGN,
        EXT_ZERO,
        EXT_LUI
    } ext_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational decoder: opcode/funct -> ALU control, operand
// extension kind, shamt usage and illegal flag.
import alu_pkg::*;

module alu_decode (
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    output logic [CTRL_W-1:0] aluctrl,
    output ext_e              ext,
    output logic              use_shamt,
    output logic              illegal
);

    always_comb begin
        aluctrl   = ALU_ADD;
        ext       = EXT_REG;
        use_shamt = 1'b0;
        illegal   = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                use_shamt = 1'b1;
                unique case (funct)
                    FN_ADD, FN_ADDU: aluctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: aluctrl = ALU_SUB;
                    FN_AND:  aluctrl = ALU_AND;
                    FN_OR:   aluctrl = ALU_OR;
                    FN_XOR:  aluctrl = ALU_XOR;
                    FN_NOR:  aluctrl = ALU_NOR;
                    FN_SLT:  aluctrl = ALU_SLT;
                    FN_SLTU: aluctrl = ALU_SLTU;
                    FN_SLL:  aluctrl = ALU_SLL;
                    FN_SRL:  aluctrl = ALU_SRL;
                    FN_SRA:  aluctrl = ALU_SRA;
                    default: begin
                        use_shamt = 1'b0;
                        illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                aluctrl = ALU_ADD;
                ext     = EXT_SIGN;
            end
            OP_SLTI: begin
                aluctrl = ALU_SLT;
                ext     = EXT_SIGN;
            end
            OP_SLTIU: begin
                aluctrl = ALU_SLTU;
                ext     = EXT_SIGN;
            end
            OP_ANDI: begin
                aluctrl = ALU_AND;
                ext     = EXT_ZERO;
            end
            OP_ORI: begin
                aluctrl = ALU_OR;
                ext     = EXT_ZERO;
            end
            OP_XORI: begin
                aluctrl = ALU_XOR;
                ext     = EXT_ZERO;
            end
            OP_LUI: begin
                aluctrl = ALU_LUI;
                ext     = EXT_LUI;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes, builds ALU operands, registers them
// behind a 2-entry skid (output reg + skid reg). FWD_EN adds WB forwarding.
// Ports: clk/rst_n (sync, active-low), flush, id_* valid/ready input
// bundle, ex_* valid/ready ALU bundle, wb_* forwarding source (FWD_EN).
import alu_pkg::*;

module alu_issue_stage #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int CTRL_W  = alu_pkg::CTRL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [5:0]         id_opcode,
    input  logic [5:0]         id_funct,
    input  logic [SHAMT_W-1:0] id_shamt,
    input  logic [15:0]        id_imm,
    input  logic [4:0]         id_rs_idx,
    input  logic [4:0]         id_rt_idx,
    input  logic [DATA_W-1:0]  id_rs_val,
    input  logic [DATA_W-1:0]  id_rt_val,
`ifdef FWD_EN
    input  logic               wb_we,
    input  logic [4:0]         wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
`endif
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [DATA_W-1:0]  ex_in1,
    output logic [DATA_W-1:0]  ex_in2,
    output logic [SHAMT_W-1:0] ex_shamt,
    output logic [CTRL_W-1:0]  ex_aluctrl,
    output logic               ex_illegal
);

    typedef struct packed {
        logic [DATA_W-1:0]  in1;
        logic [DATA_W-1:0]  in2;
        logic [SHAMT_W-1:0] shamt;
        logic [CTRL_W-1:0]  ctrl;
        logic               ill;
    } ent_t;

    logic              dec_use_sh;
    logic              dec_ill;
    logic [3:0]        dec_ctrl;
    ext_e              dec_ext;
    logic [DATA_W-1:0] rs_v;
    logic [DATA_W-1:0] rt_v;
    ent_t              new_e;
    ent_t              out_e;
    ent_t              sk_e;
    logic              out_v;
    logic              sk_v;
    logic              acc;

    alu_decode u_dec (
        .opcode    (id_opcode),
        .funct     (id_funct),
        .aluctrl   (dec_ctrl),
        .ext       (dec_ext),
        .use_shamt (dec_use_sh),
        .illegal   (dec_ill)
    );

`ifdef FWD_EN
    always_comb begin
        rs_v = id_rs_val;
        rt_v = id_rt_val;
        if (wb_we && wb_rd != 5'd0 && wb_rd == id_rs_idx)
            rs_v = wb_data;
        if (wb_we && wb_rd != 5'd0 && wb_rd == id_rt_idx)
            rt_v = wb_data;
    end
`else
    logic unused_idx;
    assign unused_idx = ^{id_rs_idx, id_rt_idx};
    assign rs_v = id_rs_val;
    assign rt_v = id_rt_val;
`endif

    // Illegal entries still issue, but with neutral operands
    always_comb begin
        new_e      = '0;
        new_e.ctrl = CTRL_W'(dec_ctrl);
        new_e.ill  = dec_ill;
        if (!dec_ill) begin
            unique case (dec_ext)
                EXT_REG: begin
                    new_e.in1 = rs_v;
                    new_e.in2 = rt_v;
                end
                EXT_SIGN: begin
                    new_e.in1 = rs_v;
                    new_e.in2 = {{(DATA_W-16){id_imm[15]}}, id_imm};
                end
                EXT_ZERO: begin
                    new_e.in1 = rs_v;
                    new_e.in2 = {{(DATA_W-16){1'b0}}, id_imm};
                end
                EXT_LUI: begin
                    new_e.in2 = {id_imm, {(DATA_W-16){1'b0}}};
                end
            endcase
            if (dec_use_sh)
                new_e.shamt = id_shamt;
        end
    end

    // id_ready is a pure register output: no path from ex_ready
    assign id_ready = !sk_v;
    assign acc      = id_valid && id_ready;

    // Skid is only ever occupied while the output reg is full
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_v <= 1'b0;
            sk_v  <= 1'b0;
            out_e <= '0;
            sk_e  <= '0;
        end else if (flush) begin
            out_v <= 1'b0;
            sk_v  <= 1'b0;
        end else if (!out_v || ex_ready) begin
            if (sk_v) begin
                out_e <= sk_e;
                out_v <= 1'b1;
                sk_v  <= 1'b0;
            end else if (acc) begin
                out_e <= new_e;
                out_v <= 1'b1;
            end else begin
                out_v <= 1'b0;
            end
        end else if (acc) begin
            sk_e <= new_e;
            sk_v <= 1'b1;
        end
    end

    assign ex_valid   = out_v;
    assign ex_in1     = out_e.in1;
    assign ex_in2     = out_e.in2;
    assign ex_shamt   = out_e.shamt;
    assign ex_aluctrl = out_e.ctrl;
    assign ex_illegal = out_e.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode table plus
// backpressure, flush, reset and optional forwarding sequences.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [4:0]  id_shamt;
    logic [15:0] id_imm;
    logic [4:0]  id_rs_idx;
    logic [4:0]  id_rt_idx;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
`ifdef FWD_EN
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`endif
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_in1;
    logic [31:0] ex_in2;
    logic [4:0]  ex_shamt;
    logic [3:0]  ex_aluctrl;
    logic        ex_illegal;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_opcode  (id_opcode),
        .id_funct   (id_funct),
        .id_shamt   (id_shamt),
        .id_imm     (id_imm),
        .id_rs_idx  (id_rs_idx),
        .id_rt_idx  (id_rt_idx),
        .id_rs_val  (id_rs_val),
        .id_rt_val  (id_rt_val),
`ifdef FWD_EN
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
`endif
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_in1     (ex_in1),
        .ex_in2     (ex_in2),
        .ex_shamt   (ex_shamt),
        .ex_aluctrl (ex_aluctrl),
        .ex_illegal (ex_illegal)
    );

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [4:0]  esh;
        logic [3:0]  ec;
        logic        eill;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [15:0] imm,
                         input logic [31:0] rs, input logic [31:0] rt);
        id_opcode = op;
        id_funct  = fn;
        id_shamt  = sh;
        id_imm    = imm;
        id_rs_val = rs;
        id_rt_val = rt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        id_valid  = 1'b0;
        ex_ready  = 1'b1;
        id_rs_idx = 5'd0;
        id_rt_idx = 5'd0;
`ifdef FWD_EN
        wb_we     = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'd0;
`endif
        drive(6'h00, 6'h20, 5'd0, 16'h0, 32'd0, 32'd0);

        //        op     fn     sh   imm       rs            rt            in1           in2           sh  ctrl ill
        tbl[0]  = '{6'h00, 6'h20, 5'd0,  16'h0000, 32'd10,       32'd20,       32'd10,       32'd20,       5'd0,  4'd0,  1'b0};
        tbl[1]  = '{6'h08, 6'h00, 5'd7,  16'hFFFF, 32'd5,        32'd9,        32'd5,        32'hFFFFFFFF, 5'd0,  4'd0,  1'b0};
        tbl[2]  = '{6'h0D, 6'h00, 5'd0,  16'hFFFF, 32'd5,        32'd9,        32'd5,        32'h0000FFFF, 5'd0,  4'd3,  1'b0};
        tbl[3]  = '{6'h00, 6'h00, 5'd2,  16'h0000, 32'd7,        32'd10,       32'd7,        32'd10,       5'd2,  4'd8,  1'b0};
        tbl[4]  = '{6'h0F, 6'h00, 5'd0,  16'h1234, 32'd77,       32'd9,        32'd0,        32'h12340000, 5'd0,  4'd11, 1'b0};
        tbl[5]  = '{6'h3F, 6'h20, 5'd3,  16'h0055, 32'd1,        32'd2,        32'd0,        32'd0,        5'd0,  4'd0,  1'b1};
        tbl[6]  = '{6'h00, 6'h22, 5'd0,  16'h0000, 32'd30,       32'd8,        32'd30,       32'd8,        5'd0,  4'd1,  1'b0};
        tbl[7]  = '{6'h00, 6'h03, 5'd31, 16'h0000, 32'd1,        32'h80000000, 32'd1,        32'h80000000, 5'd31, 4'd10, 1'b0};
        tbl[8]  = '{6'h0A, 6'h00, 5'd0,  16'h8000, 32'd4,        32'd0,        32'd4,        32'hFFFF8000, 5'd0,  4'd6,  1'b0};
        tbl[9]  = '{6'h0C, 6'h00, 5'd0,  16'h8000, 32'd4,        32'd0,        32'd4,        32'h00008000, 5'd0,  4'd2,  1'b0};
        tbl[10] = '{6'h00, 6'h2B, 5'd0,  16'h0000, 32'd1,        32'd2,        32'd1,        32'd2,        5'd0,  4'd7,  1'b0};
        tbl[11] = '{6'h00, 6'h01, 5'd4,  16'h0000, 32'd1,        32'd2,        32'd0,        32'd0,        5'd0,  4'd0,  1'b1};
        tbl[12] = '{6'h09, 6'h00, 5'd0,  16'h0001, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFF, 32'd1,        5'd0,  4'd0,  1'b0};
        tbl[13] = '{6'h0E, 6'h00, 5'd0,  16'hF0F0, 32'd6,        32'd3,        32'd6,        32'h0000F0F0, 5'd0,  4'd4,  1'b0};
        tbl[14] = '{6'h00, 6'h27, 5'd0,  16'h0000, 32'd6,        32'd3,        32'd6,        32'd3,        5'd0,  4'd5,  1'b0};
        tbl[15] = '{6'h00, 6'h25, 5'd0,  16'h0000, 32'd6,        32'd3,        32'd6,        32'd3,        5'd0,  4'd3,  1'b0};
        tbl[16] = '{6'h00, 6'h02, 5'd1,  16'h0000, 32'd6,        32'd3,        32'd6,        32'd3,        5'd1,  4'd9,  1'b0};
        tbl[17] = '{6'h0B, 6'h00, 5'd0,  16'hFFFE, 32'd6,        32'd3,        32'd6,        32'hFFFFFFFE, 5'd0,  4'd7,  1'b0};

        // Reset state
        step();
        step();
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_id_ready", 32'(id_ready), 32'd1);
        chk("rst_in1", ex_in1, 32'd0);
        chk("rst_in2", ex_in2, 32'd0);
        chk("rst_shamt", 32'(ex_shamt), 32'd0);
        chk("rst_ctrl", 32'(ex_aluctrl), 32'd0);
        chk("rst_ill", 32'(ex_illegal), 32'd0);
        rst_n = 1'b1;
        step();

        // Streaming decode table, ex_ready held high
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].op, tbl[i].fn, tbl[i].sh, tbl[i].imm,
                  tbl[i].rs, tbl[i].rt);
            id_valid = 1'b1;
            step();
            chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'd1);
            chk($sformatf("v%0d_in1", i), ex_in1, tbl[i].e1);
            chk($sformatf("v%0d_in2", i), ex_in2, tbl[i].e2);
            chk($sformatf("v%0d_shamt", i), 32'(ex_shamt), 32'(tbl[i].esh));
            chk($sformatf("v%0d_ctrl", i), 32'(ex_aluctrl), 32'(tbl[i].ec));
            chk($sformatf("v%0d_ill", i), 32'(ex_illegal), 32'(tbl[i].eill));
        end
        id_valid = 1'b0;
        step();
        chk("drain_valid", 32'(ex_valid), 32'd0);
        chk("drain_hold_in2", ex_in2, 32'hFFFFFFFE);

        // Backpressure: A to output, B to skid, C refused
        ex_ready = 1'b0;
        drive(6'h08, 6'h00, 5'd0, 16'h0001, 32'd1, 32'd0);
        id_valid = 1'b1;
        step();
        chk("bp_a_valid", 32'(ex_valid), 32'd1);
        chk("bp_a_ready", 32'(id_ready), 32'd1);
        drive(6'h00, 6'h20, 5'd0, 16'h0000, 32'd2, 32'd3);
        step();
        chk("bp_b_ready", 32'(id_ready), 32'd0);
        chk("bp_a_held", ex_in1, 32'd1);
        drive(6'h00, 6'h22, 5'd0, 16'h0000, 32'd9, 32'd9);
        step();
        chk("bp_full_ready", 32'(id_ready), 32'd0);
        chk("bp_full_a_held", ex_in1, 32'd1);
        id_valid = 1'b0;
        ex_ready = 1'b1;
        step();
        chk("bp_b_valid", 32'(ex_valid), 32'd1);
        chk("bp_b_in1", ex_in1, 32'd2);
        chk("bp_b_in2", ex_in2, 32'd3);
        chk("bp_ready_back", 32'(id_ready), 32'd1);
        step();
        chk("bp_empty", 32'(ex_valid), 32'd0);
        chk("bp_hold_data", ex_in1, 32'd2);

        // Accept + pop in same cycle keeps FIFO order
        ex_ready = 1'b0;
        drive(6'h00, 6'h20, 5'd0, 16'h0000, 32'd40, 32'd0);
        id_valid = 1'b1;
        step();
        drive(6'h00, 6'h20, 5'd0, 16'h0000, 32'd41, 32'd0);
        step();
        ex_ready = 1'b1;
        drive(6'h00, 6'h20, 5'd0, 16'h0000, 32'd42, 32'd0);
        step();
        chk("ord_1", ex_in1, 32'd41);
        chk("ord_1_ready", 32'(id_ready), 32'd1);
        step();
        chk("ord_2", ex_in1, 32'd42);
        id_valid = 1'b0;
        step();

        // Flush with both entries full and id_valid asserted
        ex_ready = 1'b0;
        drive(6'h00, 6'h20, 5'd0, 16'h0000, 32'd50, 32'd0);
        id_valid = 1'b1;
        step();
        step();
        chk("fl_full", 32'(id_ready), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        id_valid = 1'b0;
        chk("fl_valid", 32'(ex_valid), 32'd0);
        chk("fl_ready", 32'(id_ready), 32'd1);

        // Flush discards a same-cycle accept
        drive(6'h00, 6'h20, 5'd0, 16'h0000, 32'd60, 32'd0);
        id_valid = 1'b1;
        step();
        drive(6'h00, 6'h20, 5'd0, 16'h0000, 32'd61, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        id_valid = 1'b0;
        chk("fl2_valid", 32'(ex_valid), 32'd0);
        step();
        chk("fl2_still_empty", 32'(ex_valid), 32'd0);
        chk("fl2_ready", 32'(id_ready), 32'd1);

        // Reset mid-stall drops held entries
        drive(6'h00, 6'h20, 5'd0, 16'h0000, 32'd70, 32'd0);
        id_valid = 1'b1;
        step();
        step();
        id_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mrst_valid", 32'(ex_valid), 32'd0);
        chk("mrst_ready", 32'(id_ready), 32'd1);
        chk("mrst_in1", ex_in1, 32'd0);
        ex_ready = 1'b1;

`ifdef FWD_EN
        drive(6'h00, 6'h20, 5'd0, 16'h0000, 32'd5, 32'd6);
        id_rs_idx = 5'd3;
        id_rt_idx = 5'd4;
        wb_we     = 1'b1;
        wb_rd     = 5'd3;
        wb_data   = 32'd99;
        id_valid  = 1'b1;
        step();
        chk("fwd_rs", ex_in1, 32'd99);
        chk("fwd_rt_nomatch", ex_in2, 32'd6);
        id_rs_idx = 5'd0;
        wb_rd     = 5'd0;
        step();
        chk("fwd_r0", ex_in1, 32'd5);
        id_rs_idx = 5'd4;
        wb_rd     = 5'd4;
        step();
        chk("fwd_both_rs", ex_in1, 32'd99);
        chk("fwd_both_rt", ex_in2, 32'd99);
        id_valid = 1'b0;
        wb_we    = 1'b0;
        step();
`endif

        // Illegal opcode after reset, single shot
        drive(6'h3F, 6'h00, 5'd5, 16'hABCD, 32'd8, 32'd9);
        id_valid = 1'b1;
        step();
        id_valid = 1'b0;
        chk("ill_flag", 32'(ex_illegal), 32'd1);
        chk("ill_in1", ex_in1, 32'd0);
        chk("ill_in2", ex_in2, 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
